// File: rtl/mmio_cmd_sched.sv
// mmio_cmd_sched: MMIO-programmed command queue that launches accelerator commands in FIFO order.
//   Optional macro CMD_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES); without it timeout is 0.
//   Ports: clk, reset (sync, active-high); pkt_valid/pkt_addr/pkt_data MMIO write strobe;
//          done completion pulse; start launch pulse with cmd_src/cmd_dst/cmd_len;
//          busy, sync (queue drained pulse), sticky overflow/zero_len/timeout, q_count occupancy.
module mmio_cmd_sched #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pkt_valid,
    input  logic [15:0]                    pkt_addr,
    input  logic [63:0]                    pkt_data,
    input  logic                           done,
    output logic                           start,
    output logic [63:0]                    cmd_src,
    output logic [63:0]                    cmd_dst,
    output logic [31:0]                    cmd_len,
    output logic                           busy,
    output logic                           sync,
    output logic                           overflow,
    output logic                           zero_len,
    output logic                           timeout,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [63:0]    src_q, src_d, dst_q, dst_d;
    logic [31:0]    len_q, len_d;
    logic [63:0]    cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
    logic [31:0]    cmd_len_q, cmd_len_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d, zero_len_q, zero_len_d;
    logic [159:0]   mem_q [QUEUE_DEPTH];
    logic           doorbell, full, push, pop, expire;

    always_comb begin
        src_d      = (pkt_valid && pkt_addr == 16'h0040) ? pkt_data : src_q;
        dst_d      = (pkt_valid && pkt_addr == 16'h0042) ? pkt_data : dst_q;
        len_d      = (pkt_valid && pkt_addr == 16'h0044) ? pkt_data[31:0] : len_q;
        doorbell   = pkt_valid && pkt_addr == 16'h0046;
        // full is judged on the pre-pop count, so a pop in the same cycle cannot make room
        full       = count_q == CW'(QUEUE_DEPTH);
        push       = doorbell && !full && len_q != 32'd0;
        pop        = state_q == S_LOAD;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | (doorbell && full);
        zero_len_d = zero_len_q | (doorbell && len_q == 32'd0);
        {cmd_src_d, cmd_dst_d, cmd_len_d} = pop ? mem_q[rd_ptr_q] : {cmd_src_q, cmd_dst_q, cmd_len_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cmd_src_q  <= '0;
            cmd_dst_q  <= '0;
            cmd_len_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            zero_len_q <= 1'b0;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            cmd_src_q  <= cmd_src_d;
            cmd_dst_q  <= cmd_dst_d;
            cmd_len_q  <= cmd_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            zero_len_q <= zero_len_d;
        end
    end

    // Entry contents need no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {src_q, dst_q, len_q};
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        // cleared while launching so it starts at zero on the first WAIT cycle
        tmo_cnt_d = state_q == S_LAUNCH ? '0 : state_q == S_WAIT ? tmo_cnt_q + TW'(1) : tmo_cnt_q;
        expire    = state_q == S_WAIT && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
        timeout_d = timeout_q | (expire && !done);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0 & (|TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = count_q != '0 ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   state_d = (done || expire) ? (count_q != '0 ? S_LOAD : S_DRAIN) : S_WAIT;
            S_DRAIN:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start    = state_q == S_LAUNCH;
        busy     = state_q == S_LAUNCH || state_q == S_WAIT;
        sync     = state_q == S_DRAIN;
        cmd_src  = cmd_src_q;
        cmd_dst  = cmd_dst_q;
        cmd_len  = cmd_len_q;
        overflow = overflow_q;
        zero_len = zero_len_q;
        q_count  = count_q;
    end
endmodule

// File: tb/tb_mmio_cmd_sched.sv
// tb_mmio_cmd_sched: directed self-checking bench for mmio_cmd_sched.
module tb_mmio_cmd_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [15:0] pkt_addr = '0;
    logic [63:0] pkt_data = '0;
    logic        done = 1'b0;
    logic        start, busy, sync, overflow, zero_len, timeout;
    logic [63:0] cmd_src, cmd_dst;
    logic [31:0] cmd_len;
    logic [2:0]  q_count;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int sync_cnt = 0;
    int s0, y0;
    logic [31:0] len_log[$];

    mmio_cmd_sched #(.QUEUE_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_addr(pkt_addr),
        .pkt_data(pkt_data), .done(done), .start(start), .cmd_src(cmd_src),
        .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy), .sync(sync),
        .overflow(overflow), .zero_len(zero_len), .timeout(timeout), .q_count(q_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            len_log.push_back(cmd_len);
        end
        if (sync) sync_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        pkt_valid = 1'b1;
        pkt_addr  = a;
        pkt_data  = d;
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // advance until the DUT sits in WAIT (busy without start)
    task automatic wait_wait(input string tag);
        int i;
        for (i = 0; i < 20 && !(busy && !start); i++) tick();
        chk(tag, {62'd0, busy, start}, 64'd2);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_q_count", q_count, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync", sync, 0);
        chk("rst_flags", {overflow, zero_len, timeout}, 0);
        chk("rst_cmd", cmd_src | cmd_dst | cmd_len, 0);
        reset = 1'b0;

        // single command, latency and done-with-start ignored
        wr(16'h0040, 64'h1000);
        wr(16'h0042, 64'h2000);
        wr(16'h0044, 64'h8);
        wr(16'h0046, 64'hDEAD_BEEF);
        chk("t1_q_count", q_count, 1);
        chk("t1_start_n1", start, 0);
        tick();
        chk("t1_start_n2", start, 0);
        tick();
        chk("t1_start", start, 1);
        chk("t1_src", cmd_src, 64'h1000);
        chk("t1_dst", cmd_dst, 64'h2000);
        chk("t1_len", cmd_len, 8);
        chk("t1_busy", busy, 1);
        chk("t1_q_empty", q_count, 0);
        pulse_done();
        chk("t1_done_at_start_ignored", {busy, start}, 2'b10);
        tick();
        tick();
        chk("t1_wait_busy", busy, 1);
        pulse_done();
        chk("t1_sync", sync, 1);
        chk("t1_busy_clr", busy, 0);
        chk("t1_src_stable", cmd_src, 64'h1000);
        tick();
        chk("t1_sync_one", sync, 0);

        // three back-to-back doorbells
        len_log.delete();
        y0 = sync_cnt;
        wr(16'h0044, 64'd1);
        wr(16'h0046, 64'd0);
        wr(16'h0044, 64'd2);
        wr(16'h0046, 64'd0);
        wr(16'h0044, 64'd3);
        wr(16'h0046, 64'd0);
        for (int k = 0; k < 3; k++) begin
            wait_wait("t2_wait");
            repeat (4) tick();
            pulse_done();
        end
        chk("t2_sync", sync, 1);
        repeat (4) tick();
        chk("t2_starts", len_log.size(), 3);
        chk("t2_len0", len_log.size() > 0 ? len_log[0] : 32'hX, 1);
        chk("t2_len1", len_log.size() > 1 ? len_log[1] : 32'hX, 2);
        chk("t2_len2", len_log.size() > 2 ? len_log[2] : 32'hX, 3);
        chk("t2_sync_cnt", sync_cnt - y0, 1);

        // overflow with done held low
        chk("t3_ovf_pre", overflow, 0);
        s0 = start_cnt;
        y0 = sync_cnt;
        wr(16'h0044, 64'd4);
        wr(16'h0046, 64'd0);
        wr(16'h0046, 64'd0);
        wr(16'h0046, 64'd0);
        chk("t3_push_pop_same", q_count, 2);
        wr(16'h0046, 64'd0);
        wr(16'h0046, 64'd0);
        wr(16'h0046, 64'd0);
        chk("t3_q_count", q_count, 4);
        chk("t3_overflow", overflow, 1);
        for (int k = 0; k < 5; k++) begin
            wait_wait("t3_wait");
            pulse_done();
        end
        repeat (10) tick();
        chk("t3_starts", start_cnt - s0, 5);
        chk("t3_sync_cnt", sync_cnt - y0, 1);
        chk("t3_q_empty", q_count, 0);

        // zero length doorbell
        chk("t4_zl_pre", zero_len, 0);
        s0 = start_cnt;
        y0 = sync_cnt;
        wr(16'h0044, 64'd0);
        wr(16'h0046, 64'd0);
        chk("t4_zero_len", zero_len, 1);
        chk("t4_q_count", q_count, 0);
        repeat (8) tick();
        chk("t4_no_start", start_cnt - s0, 0);
        chk("t4_no_sync", sync_cnt - y0, 0);

        // reset during WAIT
        wr(16'h0044, 64'd5);
        wr(16'h0046, 64'd0);
        wait_wait("t5_wait");
        s0 = start_cnt;
        y0 = sync_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_outs", {start, busy, sync, overflow, zero_len, timeout}, 0);
        chk("t5_cmd", cmd_src | cmd_dst | cmd_len, 0);
        chk("t5_q_count", q_count, 0);
        pulse_done();
        repeat (5) tick();
        chk("t5_no_start", start_cnt - s0, 0);
        chk("t5_no_sync", sync_cnt - y0, 0);
        chk("t5_busy", busy, 0);

        // watchdog
        wr(16'h0044, 64'd2);
        wr(16'h0046, 64'd0);
        wait_wait("t6_wait");
`ifdef CMD_TIMEOUT_EN
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("t6_busy", busy, 0);
        chk("t6_timeout", timeout, 1);
        chk("t6_sync", sync, 1);
`else
        repeat (40) tick();
        chk("t6_busy_hold", busy, 1);
        chk("t6_timeout_zero", timeout, 0);
        pulse_done();
        chk("t6_sync", sync, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
